// File: rtl/mem_xbar_arbiter_if.sv
// Core-side request/response bundle for mem_xbar_arbiter.
// Port i of every packed vector occupies slice i (e.g. addr[i*AddrWidth +: AddrWidth]).
//   master: req/we/be/addr/wdata out, gnt/rvalid/rdata/err in
//   slave : the arbiter's view (directions reversed)
interface mem_xbar_arbiter_if #(
  parameter int unsigned NumPorts  = 2,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);
  localparam int unsigned BeWidth = DataWidth / 8;

  logic [NumPorts-1:0]           req;
  logic [NumPorts-1:0]           we;
  logic [NumPorts*BeWidth-1:0]   be;
  logic [NumPorts*AddrWidth-1:0] addr;
  logic [NumPorts*DataWidth-1:0] wdata;
  logic [NumPorts-1:0]           gnt;
  logic [NumPorts-1:0]           rvalid;
  logic [DataWidth-1:0]          rdata;
  logic [NumPorts-1:0]           err;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/mem_xbar_arbiter.sv
// N-port req/gnt/rvalid arbiter in front of a single-port RAM.
// Ports:
//   clk, reset       clock, synchronous active-low reset
//   bus (slave)      per-port req/we/be/addr/wdata in; gnt/rvalid/err per port, shared rdata out
//   mem_*_o          RAM request channel (word address, MW bits)
//   mem_rvalid_i/mem_rdata_i  RAM response, exactly one cycle after mem_req_o
// Grants are combinational; out-of-range accesses are granted, never reach
// the RAM, and answer with err one cycle later.
module mem_xbar_arbiter #(
  parameter int unsigned          NumPorts  = 2,
  parameter int unsigned          AddrWidth = 32,
  parameter int unsigned          DataWidth = 32,
  parameter int unsigned          Depth     = 16384,
  parameter logic [AddrWidth-1:0] BaseAddr  = '0,
  parameter int unsigned          ArbMode   = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  mem_xbar_arbiter_if.slave              bus,
  output logic                           mem_req_o,
  output logic                           mem_we_o,
  output logic [DataWidth/8-1:0]         mem_be_o,
  output logic [$clog2(Depth)-1:0]       mem_addr_o,
  output logic [DataWidth-1:0]           mem_wdata_o,
  input  logic                           mem_rvalid_i,
  input  logic [DataWidth-1:0]           mem_rdata_i
);

  localparam int unsigned MW = $clog2(Depth);
  localparam int unsigned BW = DataWidth / 8;
  localparam int unsigned PW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam logic [AddrWidth:0] Limit = (AddrWidth+1)'(64'(Depth) * 64'd4);

  logic [PW-1:0] rr_q, rr_d;
  logic          resp_valid_q;
  logic [PW-1:0] resp_port_q;
  logic          resp_err_q;

  logic                 any_c;
  logic [PW-1:0]        win_c;
  logic [AddrWidth-1:0] addr_w;
  logic [AddrWidth-1:0] off_c;
  logic                 in_range_c;

  // Winner selection: fixed priority, or round-robin search from rr_q.
  always_comb begin
    any_c = 1'b0;
    win_c = '0;
    if (ArbMode == 0 || NumPorts == 1) begin
      for (int i = NumPorts - 1; i >= 0; i--) begin
        if (bus.req[PW'(i)]) begin
          any_c = 1'b1;
          win_c = PW'(i);
        end
      end
    end else begin
      for (int unsigned off = 0; off < NumPorts; off++) begin
        int unsigned idx;
        idx = 32'(rr_q) + off;
        if (idx >= NumPorts) idx = idx - NumPorts;
        if (!any_c && bus.req[PW'(idx)]) begin
          any_c = 1'b1;
          win_c = PW'(idx);
        end
      end
    end
  end

  // Round-robin pointer advances past the winner; fixed mode keeps it at 0.
  always_comb begin
    rr_d = rr_q;
    if (ArbMode != 0 && NumPorts > 1 && any_c) begin
      rr_d = (win_c == PW'(NumPorts - 1)) ? '0 : PW'(win_c + PW'(1));
    end
  end

  // Winner's request attributes and range check (below-base addresses wrap high).
  always_comb begin
    addr_w      = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      if (win_c == PW'(i)) begin
        addr_w      = bus.addr[i*AddrWidth +: AddrWidth];
        mem_we_o    = bus.we[i];
        mem_be_o    = bus.be[i*BW +: BW];
        mem_wdata_o = bus.wdata[i*DataWidth +: DataWidth];
      end
    end
    off_c      = addr_w - BaseAddr;
    in_range_c = ({1'b0, off_c} < Limit);
    mem_addr_o = off_c[MW+1:2];
    mem_req_o  = reset && any_c && in_range_c;
  end

  // Grant and response fan-out; only resp_port_q sees rvalid/err.
  always_comb begin
    bus.gnt    = '0;
    bus.rvalid = '0;
    bus.err    = '0;
    bus.rdata  = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      bus.gnt[i] = reset && any_c && (win_c == PW'(i));
      if (resp_valid_q && resp_port_q == PW'(i)) begin
        bus.rvalid[i] = resp_err_q || mem_rvalid_i;
        bus.err[i]    = resp_err_q;
      end
    end
    if (resp_valid_q && !resp_err_q && mem_rvalid_i) bus.rdata = mem_rdata_i;
  end

  // Outstanding-response tracking; reset drops any pending response.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_port_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      rr_q         <= rr_d;
      resp_valid_q <= any_c;
      if (any_c) begin
        resp_port_q <= win_c;
        resp_err_q  <= !in_range_c;
      end
    end
  end

endmodule

// File: tb/tb_mem_xbar_arbiter.sv
// Directed bench: a 2-port fixed-priority instance backed by a small RAM
// model, and a 3-port round-robin instance with a bare 1-cycle responder.
module tb_mem_xbar_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  mem_xbar_arbiter_if #(.NumPorts(2)) if_fix ();
  mem_xbar_arbiter_if #(.NumPorts(3)) if_rr ();

  logic        fx_req, fx_we, fx_rvalid;
  logic [3:0]  fx_be;
  logic [13:0] fx_addr;
  logic [31:0] fx_wdata, fx_rdata;
  logic        rr_req, rr_we, rr_rvalid;
  logic [3:0]  rr_be;
  logic [13:0] rr_addr;
  logic [31:0] rr_wdata;
  logic [31:0] ram_q [256];

  mem_xbar_arbiter #(.NumPorts(2), .ArbMode(0)) u_fix (
    .clk(clk), .reset(reset), .bus(if_fix),
    .mem_req_o(fx_req), .mem_we_o(fx_we), .mem_be_o(fx_be), .mem_addr_o(fx_addr),
    .mem_wdata_o(fx_wdata), .mem_rvalid_i(fx_rvalid), .mem_rdata_i(fx_rdata)
  );

  mem_xbar_arbiter #(.NumPorts(3), .ArbMode(1)) u_rr (
    .clk(clk), .reset(reset), .bus(if_rr),
    .mem_req_o(rr_req), .mem_we_o(rr_we), .mem_be_o(rr_be), .mem_addr_o(rr_addr),
    .mem_wdata_o(rr_wdata), .mem_rvalid_i(rr_rvalid), .mem_rdata_i(32'h0)
  );

  // 1-cycle RAM model for the fixed-priority instance.
  always @(posedge clk) begin
    fx_rvalid <= fx_req;
    fx_rdata  <= ram_q[fx_addr[7:0]];
    if (fx_req && fx_we)
      for (int b = 0; b < 4; b++)
        if (fx_be[b]) ram_q[fx_addr[7:0]][8*b +: 8] <= fx_wdata[8*b +: 8];
  end

  always @(posedge clk) rr_rvalid <= rr_req;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic fx_port(input int p, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
    if_fix.we[p]              = we;
    if_fix.addr[p*32 +: 32]   = addr;
    if_fix.wdata[p*32 +: 32]  = wdata;
    if_fix.be[p*4 +: 4]       = be;
  endtask

  logic [2:0] rr_exp [6];

  initial begin
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    for (int i = 0; i < 256; i++) ram_q[i] = 32'h0;
    fx_rvalid = 1'b0;
    rr_rvalid = 1'b0;
    reset = 1'b0;
    if_fix.req = 2'b11; if_fix.we = '0; if_fix.be = '0; if_fix.addr = '0; if_fix.wdata = '0;
    if_rr.req  = 3'b000; if_rr.we = '0; if_rr.be = '0; if_rr.addr = '0; if_rr.wdata = '0;

    // Reset held with both ports requesting.
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_gnt", 64'(if_fix.gnt), 64'h0);
    end
    check("rst_mem_req", 64'(fx_req), 64'h0);
    check("rst_rvalid", 64'(if_fix.rvalid), 64'h0);

    // Fixed priority: port 0 wins while both request.
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("fix_gnt", 64'(if_fix.gnt), 64'h1);
      check("fix_rvalid", 64'(if_fix.rvalid), (c == 0) ? 64'h0 : 64'h1);
      tick();
    end
    check("fix_rvalid_last", 64'(if_fix.rvalid), 64'h1);

    // Port 1 writes then reads back-to-back.
    if_fix.req = 2'b10;
    fx_port(1, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
    #1;
    check("wr_gnt", 64'(if_fix.gnt), 64'h2);
    check("wr_mem_req", 64'(fx_req), 64'h1);
    check("wr_mem_we", 64'(fx_we), 64'h1);
    check("wr_mem_addr", 64'(fx_addr), 64'h40);
    check("wr_mem_wdata", 64'(fx_wdata), 64'hDEADBEEF);
    tick();
    fx_port(1, 1'b0, 32'h100, 32'h0, 4'hF);
    #1;
    check("wr_rvalid", 64'(if_fix.rvalid), 64'h2);
    check("wr_err", 64'(if_fix.err), 64'h0);
    check("rd_mem_addr", 64'(fx_addr), 64'h40);
    check("rd_mem_we", 64'(fx_we), 64'h0);
    tick();
    if_fix.req = 2'b00;
    #1;
    check("rd_rvalid", 64'(if_fix.rvalid), 64'h2);
    check("rd_rdata", 64'(if_fix.rdata), 64'hDEADBEEF);
    check("rd_err", 64'(if_fix.err), 64'h0);
    tick();

    // Out-of-range read: granted, no RAM request, error response.
    if_fix.req = 2'b01;
    fx_port(0, 1'b0, 32'h0001_0000, 32'h0, 4'hF);
    #1;
    check("oor_gnt", 64'(if_fix.gnt), 64'h1);
    check("oor_mem_req", 64'(fx_req), 64'h0);
    tick();
    // Last in-range word, issued back-to-back with the error response.
    fx_port(0, 1'b0, 32'h0000_FFFC, 32'h0, 4'hF);
    #1;
    check("oor_rvalid", 64'(if_fix.rvalid), 64'h1);
    check("oor_err", 64'(if_fix.err), 64'h1);
    check("oor_rdata", 64'(if_fix.rdata), 64'h0);
    check("top_mem_req", 64'(fx_req), 64'h1);
    check("top_mem_addr", 64'(fx_addr), 64'h3FFF);
    tick();
    if_fix.req = 2'b00;
    #1;
    check("top_err", 64'(if_fix.err), 64'h0);
    check("top_rvalid", 64'(if_fix.rvalid), 64'h1);
    tick();

    // Round-robin across three requesters.
    if_rr.req = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1;
      check("rr_gnt", 64'(if_rr.gnt), 64'(rr_exp[c]));
      if (c > 0) check("rr_rvalid", 64'(if_rr.rvalid), 64'(rr_exp[c-1]));
      tick();
    end
    if_rr.req = 3'b000;
    #1;
    check("rr_rvalid_last", 64'(if_rr.rvalid), 64'(rr_exp[5]));
    if_rr.req = 3'b111;
    #1;
    check("rr_gnt_wrap", 64'(if_rr.gnt), 64'h1);
    tick();
    if_rr.req = 3'b000;

    // Reset arrives right after a read is accepted.
    if_fix.req = 2'b01;
    fx_port(0, 1'b0, 32'h100, 32'h0, 4'hF);
    #1;
    check("mid_gnt", 64'(if_fix.gnt), 64'h1);
    tick();
    if_fix.req = 2'b00;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("mid_rvalid", 64'(if_fix.rvalid), 64'h0);
    check("mid_rdata", 64'(if_fix.rdata), 64'h0);
    tick();
    check("mid_rvalid2", 64'(if_fix.rvalid), 64'h0);
    if_rr.req = 3'b111;
    #1;
    check("mid_rr_ptr", 64'(if_rr.gnt), 64'h1);
    tick();
    if_rr.req = 3'b000;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1);
  end

endmodule
